exu_mul_wb_ctl: RTL

Writeback controller for the 3-stage integer multiplier (E1 capture, E2 multiply, E3 result). It carries each issued multiply's destination-register tag through E1/E2/E3 in lockstep with the multiplier datapath, honouring freeze and flush. At E3 it pairs the tag with the multiplier's 32-bit result. It presents the pair to the shared integer writeback port, buffering it in an in-order FIFO when the port is not granted. It also back-pressures multiply issue so the buffer can never overflow.

---
 rtl/exu_mul_wb_ctl_if.sv | 29 ++
 rtl/exu_mul_wb_ctl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/exu_mul_wb_ctl_if.sv
// rtl/exu_mul_wb_ctl_if.sv - issue/freeze/flush, multiplier result and writeback bundle for exu_mul_wb_ctl
//   master: pipeline side (drives issue, freeze, flush, mul_out, wb_ready)
//   slave : exu_mul_wb_ctl (drives wb_*, issue_stall, pend_*)
interface exu_mul_wb_ctl_if #(
    parameter int TAGW = 5
) ();
    logic                mul_issue_valid;
    logic [TAGW-1:0]     mul_issue_rd;
    logic                freeze;
    logic                flush;
    logic [31:0]         mul_out;
    logic                wb_ready;
    logic                wb_valid;
    logic [TAGW-1:0]     wb_rd;
    logic [31:0]         wb_data;
    logic                issue_stall;
    logic [2:0]          pend_valid;
    logic [3*TAGW-1:0]   pend_rd;

    modport master (
        output mul_issue_valid, mul_issue_rd, freeze, flush, mul_out, wb_ready,
        input  wb_valid, wb_rd, wb_data, issue_stall, pend_valid, pend_rd
    );

    modport slave (
        input  mul_issue_valid, mul_issue_rd, freeze, flush, mul_out, wb_ready,
        output wb_valid, wb_rd, wb_data, issue_stall, pend_valid, pend_rd
    );
endinterface

// File: rtl/exu_mul_wb_ctl.sv
// rtl/exu_mul_wb_ctl.sv - tag pipeline and in-order writeback buffer for the 3-stage multiplier
//   clk, rst : clock, synchronous active-high reset
//   bus      : exu_mul_wb_ctl_if.slave (issue, freeze/flush, E3 result, writeback port, stall, pending tags)
module exu_mul_wb_ctl #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    exu_mul_wb_ctl_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic            v_e1_q, v_e2_q, v_e3_q;
    logic            v_e1_d, v_e2_d, v_e3_d;
    logic [TAGW-1:0] rd_e1_q, rd_e2_q, rd_e3_q;
    logic [TAGW-1:0] rd_e1_d, rd_e2_d, rd_e3_d;

    logic [TAGW-1:0] fifo_rd_q   [DEPTH];
    logic [31:0]     fifo_data_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            e3_ret, fifo_ne, fifo_full, pop, push, push_ok;
    logic [CW:0]     occupancy;

    assign e3_ret    = v_e3_q & ~bus.freeze;
    assign fifo_ne   = (count_q != '0);
    assign fifo_full = (count_q == CW'(DEPTH));
    assign pop       = fifo_ne & bus.wb_ready;
    // Bypass only when nothing is buffered and the port takes it this cycle.
    assign push      = e3_ret & ~(~fifo_ne & bus.wb_ready);
    assign push_ok   = push & ~fifo_full;

    // Stage advance; flush still kills E1/E2 while frozen, E3 is committed.
    always_comb begin
        v_e1_d  = v_e1_q & ~bus.flush;
        v_e2_d  = v_e2_q & ~bus.flush;
        v_e3_d  = v_e3_q;
        rd_e1_d = rd_e1_q;
        rd_e2_d = rd_e2_q;
        rd_e3_d = rd_e3_q;
        if (!bus.freeze) begin
            v_e1_d  = bus.mul_issue_valid & ~bus.flush;
            v_e2_d  = v_e1_q & ~bus.flush;
            v_e3_d  = v_e2_q & ~bus.flush;
            rd_e1_d = bus.mul_issue_rd;
            rd_e2_d = rd_e1_q;
            rd_e3_d = rd_e2_q;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop)     rptr_d = rptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_e1_q  <= 1'b0;
            v_e2_q  <= 1'b0;
            v_e3_q  <= 1'b0;
            rd_e1_q <= '0;
            rd_e2_q <= '0;
            rd_e3_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            v_e1_q  <= v_e1_d;
            v_e2_q  <= v_e2_d;
            v_e3_q  <= v_e3_d;
            rd_e1_q <= rd_e1_d;
            rd_e2_q <= rd_e2_d;
            rd_e3_q <= rd_e3_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_rd_q[wptr_q]   <= rd_e3_q;
            fifo_data_q[wptr_q] <= bus.mul_out;
        end
    end

    // Buffered entries are older than E3, so they always win the port.
    always_comb begin
        bus.wb_valid = fifo_ne | e3_ret;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        if (fifo_ne) begin
            bus.wb_rd   = fifo_rd_q[rptr_q];
            bus.wb_data = fifo_data_q[rptr_q];
        end else if (e3_ret) begin
            bus.wb_rd   = rd_e3_q;
            bus.wb_data = bus.mul_out;
        end
    end

    // Every in-flight multiply may still need a FIFO slot, so reserve one for each.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, v_e1_q}
                     + {{CW{1'b0}}, v_e2_q} + {{CW{1'b0}}, v_e3_q};
    assign bus.issue_stall = (occupancy >= (CW+1)'(DEPTH));

    assign bus.pend_valid = {v_e3_q, v_e2_q, v_e1_q};
    assign bus.pend_rd    = {rd_e3_q, rd_e2_q, rd_e1_q};

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
endmodule
